// File: rtl/spi_master_cfg_if.sv
// CPU-side register interface of the configurable SPI master: configuration,
// transfer request and receive handshake.
interface spi_master_cfg_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
);
  logic [DIV_W-1:0]  clk_div;
  logic              cfg_cpol;
  logic              cfg_cpha;
  logic              cfg_lsb_first;
  logic              hold_cs;
  logic              cs_release;
  logic [DATA_W-1:0] tx_data;
  logic              start;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport master (
    output clk_div, cfg_cpol, cfg_cpha, cfg_lsb_first, hold_cs, cs_release,
    output tx_data, start,
    input  rx_data, rx_valid, busy
  );

  modport slave (
    input  clk_div, cfg_cpol, cfg_cpha, cfg_lsb_first, hold_cs, cs_release,
    input  tx_data, start,
    output rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: word width, SCK divider, CPOL/CPHA, bit order and
// chip select with optional hold across words. SCK is a registered output.
module spi_master_cfg #(
  parameter int   DATA_W    = 8,
  parameter int   DIV_W     = 8,
  parameter logic IDLE_MOSI = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  spi_master_cfg_if.slave bus,
  output logic            spi_clk,
  output logic            spi_mosi,
  input  logic            spi_miso,
  output logic            spi_cs_n
);

  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic              busy_q,     busy_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rx_data_q,  rx_data_d;
  logic              cs_n_q,     cs_n_d;
  logic              sck_q,      sck_d;
  logic              mosi_q,     mosi_d;
  logic [DIV_W-1:0]  cnt_q,      cnt_d;
  logic [EDGE_W-1:0] edge_q,     edge_d;
  logic [DIV_W-1:0]  div_q,      div_d;
  logic              cpol_q,     cpol_d;
  logic              cpha_q,     cpha_d;
  logic              lsb_q,      lsb_d;
  logic              hold_q,     hold_d;
  logic [DATA_W-1:0] tx_sr_q,    tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q,    rx_sr_d;

  logic [EDGE_W-1:0] edge_nxt;
  logic              half_done;
  logic              leading;
  logic              sample_edge;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w,
                                                   input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Odd edges are leading; CPHA selects whether leading or trailing edges sample.
  assign edge_nxt    = edge_q + EDGE_W'(1);
  assign half_done   = (cnt_q == div_q);
  assign leading     = edge_nxt[0];
  assign sample_edge = leading ^ cpha_q;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    cs_n_d     = cs_n_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    div_d      = div_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    hold_d     = hold_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;

    case (state_q)
      ST_IDLE: begin
        sck_d  = bus.cfg_cpol;
        mosi_d = IDLE_MOSI;
        cnt_d  = '0;
        edge_d = '0;
        if (bus.start) begin
          busy_d  = 1'b1;
          div_d   = bus.clk_div;
          cpol_d  = bus.cfg_cpol;
          cpha_d  = bus.cfg_cpha;
          lsb_d   = bus.cfg_lsb_first;
          hold_d  = bus.hold_cs;
          tx_sr_d = bus.tx_data;
          rx_sr_d = '0;
          // CPHA=0 needs the first bit valid before the first leading edge.
          if (!bus.cfg_cpha) begin
            mosi_d  = first_bit(bus.tx_data, bus.cfg_lsb_first);
            tx_sr_d = shift_word(bus.tx_data, bus.cfg_lsb_first);
          end
          if (cs_n_q) begin
            cs_n_d  = 1'b0;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_XFER;
          end
        end else if (bus.cs_release) begin
          cs_n_d = 1'b1;
        end
      end

      ST_SETUP: begin
        if (half_done) begin
          cnt_d   = '0;
          state_d = ST_XFER;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      ST_XFER: begin
        if (half_done) begin
          cnt_d  = '0;
          edge_d = edge_nxt;
          sck_d  = ~sck_q;
          if (sample_edge) begin
            rx_sr_d = lsb_q ? {spi_miso, rx_sr_q[DATA_W-1:1]}
                            : {rx_sr_q[DATA_W-2:0], spi_miso};
          end else if (edge_nxt != LAST_EDGE) begin
            mosi_d  = first_bit(tx_sr_q, lsb_q);
            tx_sr_d = shift_word(tx_sr_q, lsb_q);
          end
          if (edge_nxt == LAST_EDGE) begin
            mosi_d  = IDLE_MOSI;
            state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      ST_HOLD: begin
        sck_d  = cpol_q;
        mosi_d = IDLE_MOSI;
        if (half_done) begin
          cnt_d      = '0;
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          cs_n_d     = ~hold_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      cs_n_q     <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= IDLE_MOSI;
      cnt_q      <= '0;
      edge_q     <= '0;
      div_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      hold_q     <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      div_q      <= div_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      hold_q     <= hold_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign spi_clk      = sck_q;
  assign spi_mosi     = mosi_q;
  assign spi_cs_n     = cs_n_q;

endmodule
